// File: rtl/led_blink_scheduler_if.sv
// Bundle of request/status signals between the status sources and the
// LED blink scheduler. The scheduler is the slave; whoever drives the
// request lines (the status sources) uses the master modport.
interface led_blink_scheduler_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] grant;
    logic [N_REQ-1:0] done;
    logic             busy;
    logic [1:0]       LED;

    modport master (
        output req,
        input  grant,
        input  done,
        input  busy,
        input  LED
    );

    modport slave (
        input  req,
        output grant,
        output done,
        output busy,
        output LED
    );
endinterface

// File: rtl/led_blink_scheduler.sv
// Round-robin owner of the complementary LED pair. A granted requester
// gets BLINKS on/off pairs of HALF_PERIOD cycles each, followed by a GAP
// quiet interval, after which the next requester is picked starting just
// after the previous owner. One shared counter times every phase.
module led_blink_scheduler #(
    parameter int N_REQ       = 4,
    parameter int HALF_PERIOD = 5000,
    parameter int BLINKS      = 3,
    parameter int GAP         = 5000,
    parameter int CNT_W       = 33
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    led_blink_scheduler_if.slave    bus
);

    localparam int PTR_W = $clog2(N_REQ);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ON   = 2'd1;
    localparam logic [1:0] ST_OFF  = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

    // LED[0] is the active indicator, LED[1] its complement.
    localparam logic [1:0] LED_ON  = 2'b01;
    localparam logic [1:0] LED_OFF = 2'b10;

    localparam logic [N_REQ-1:0] ONE_HOT_0    = {{(N_REQ-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] HALF_LAST    = CNT_W'(HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP - 1);
    localparam logic [7:0]       BLINKS_INIT  = 8'(BLINKS);
    localparam logic [PTR_W-1:0] PTR_LAST     = PTR_W'(N_REQ - 1);

    logic [1:0]       state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [7:0]       blinks_q, blinks_d;
    logic [PTR_W-1:0] ptr_q,    ptr_d;
    logic [PTR_W-1:0] sel_q,    sel_d;
    logic [N_REQ-1:0] grant_q,  grant_d;
    logic [N_REQ-1:0] done_q,   done_d;
    logic             busy_q,   busy_d;
    logic [1:0]       led_q,    led_d;

    logic             found_s;
    logic [PTR_W-1:0] pick_s;

    // Round-robin search: first set request bit at ptr, ptr+1, ... mod N_REQ.
    // Scanning from the far end and overwriting leaves the nearest hit.
    always_comb begin
        found_s = 1'b0;
        pick_s  = ptr_q;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            int idx;
            idx = (int'(ptr_q) + i) % N_REQ;
            if (bus.req[idx]) begin
                found_s = 1'b1;
                pick_s  = PTR_W'(idx);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state logic for the arbitration / blink / gap sequence.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        blinks_d = blinks_q;
        ptr_d    = ptr_q;
        sel_d    = sel_q;
        grant_d  = grant_q;
        done_d   = {N_REQ{1'b0}};
        busy_d   = busy_q;
        led_d    = led_q;

        case (state_q)
            ST_IDLE: begin
                led_d   = LED_OFF;
                busy_d  = 1'b0;
                grant_d = {N_REQ{1'b0}};
                cnt_d   = {CNT_W{1'b0}};
                if (found_s) begin
                    grant_d  = ONE_HOT_0 << pick_s;
                    sel_d    = pick_s;
                    busy_d   = 1'b1;
                    led_d    = LED_ON;
                    blinks_d = BLINKS_INIT;
                    state_d  = ST_ON;
                end else begin
                    state_d  = ST_IDLE;
                end
            end

            ST_ON: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = {CNT_W{1'b0}};
                    led_d   = LED_OFF;
                    state_d = ST_OFF;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end

            ST_OFF: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = {CNT_W{1'b0}};
                    if (blinks_q > 8'd1) begin
                        blinks_d = blinks_q - 8'd1;
                        led_d    = LED_ON;
                        state_d  = ST_ON;
                    end else begin
                        // Burst finished: pulse done on the owner and hand
                        // priority to the requester after it.
                        done_d   = grant_q;
                        grant_d  = {N_REQ{1'b0}};
                        busy_d   = 1'b0;
                        blinks_d = 8'd0;
                        ptr_d    = (sel_q == PTR_LAST) ? {PTR_W{1'b0}}
                                                       : sel_q + PTR_W'(1);
                        state_d  = ST_GAP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_GAP: begin
                led_d   = LED_OFF;
                grant_d = {N_REQ{1'b0}};
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d  = ST_IDLE;
                cnt_d    = {CNT_W{1'b0}};
                blinks_d = 8'd0;
                grant_d  = {N_REQ{1'b0}};
                busy_d   = 1'b0;
                led_d    = LED_OFF;
            end
        endcase
    end

    // State registers with synchronous active-low reset that overrides all.
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            blinks_q <= 8'd0;
            ptr_q    <= {PTR_W{1'b0}};
            sel_q    <= {PTR_W{1'b0}};
            grant_q  <= {N_REQ{1'b0}};
            done_q   <= {N_REQ{1'b0}};
            busy_q   <= 1'b0;
            led_q    <= LED_OFF;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            blinks_q <= blinks_d;
            ptr_q    <= ptr_d;
            sel_q    <= sel_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            led_q    <= led_d;
        end
    end

    assign bus.grant = grant_q;
    assign bus.done  = done_q;
    assign bus.busy  = busy_q;
    assign bus.LED   = led_q;

endmodule

// File: tb/tb_led_blink_scheduler.sv
// Directed bench for led_blink_scheduler with HALF_PERIOD=4, BLINKS=2,
// GAP=3, N_REQ=4: one burst spans 20 cycles from grant to next grant.
// Inputs change and outputs are sampled on the falling edge.
module tb_led_blink_scheduler;

    localparam int N_REQ = 4;
    localparam int HP    = 4;
    localparam int BL    = 2;
    localparam int GP    = 3;
    localparam int SPAN  = 2 * HP * BL + GP + 1;

    logic clk_s;
    logic reset_s;
    int   n_checks;
    int   n_pass;

    led_blink_scheduler_if #(.N_REQ(N_REQ)) bus_if ();

    led_blink_scheduler #(
        .N_REQ       (N_REQ),
        .HALF_PERIOD (HP),
        .BLINKS      (BL),
        .GAP         (GP),
        .CNT_W       (33)
    ) dut (
        .CLOCK_50 (clk_s),
        .reset    (reset_s),
        .bus      (bus_if.slave)
    );

    initial begin
        clk_s = 1'b0;
        forever #5 clk_s = ~clk_s;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Called at the falling edge right after grant edge t. Checks every
    // output for k = 0..SPAN-1 and returns after edge t+SPAN-1.
    // If drop_at >= 0, req is cleared after edge t+drop_at.
    task automatic burst(input logic [3:0] g, input int drop_at);
        for (int k = 0; k < SPAN; k++) begin
            logic [1:0] exp_led;
            if (k > 0) @(negedge clk_s);
            exp_led = ((k < HP) || (k >= 2*HP && k < 3*HP)) ? 2'b01 : 2'b10;
            check($sformatf("led[g=%b k=%0d]", g, k),   32'(bus_if.LED),   32'(exp_led));
            check($sformatf("grant[g=%b k=%0d]", g, k), 32'(bus_if.grant), (k < 2*HP*BL) ? 32'(g) : 32'd0);
            check($sformatf("done[g=%b k=%0d]", g, k),  32'(bus_if.done),  (k == 2*HP*BL) ? 32'(g) : 32'd0);
            check($sformatf("busy[g=%b k=%0d]", g, k),  32'(bus_if.busy),  (k < 2*HP*BL) ? 32'd1 : 32'd0);
            if (k == drop_at) bus_if.req = 4'b0000;
        end
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        reset_s    = 1'b0;
        bus_if.req = 4'b1111;

        // Reset held for two edges with all requests asserted.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_s);
            check("rst_grant", 32'(bus_if.grant), 32'd0);
            check("rst_done",  32'(bus_if.done),  32'd0);
            check("rst_busy",  32'(bus_if.busy),  32'd0);
            check("rst_led",   32'(bus_if.LED),   32'(2'b10));
        end
        reset_s = 1'b1;

        // First edge out of reset grants requester 0, then round-robin.
        @(negedge clk_s);
        check("rr_grant0", 32'(bus_if.grant), 32'(4'b0001));
        burst(4'b0001, -1);
        @(negedge clk_s);
        check("rr_grant1", 32'(bus_if.grant), 32'(4'b0010));
        burst(4'b0010, -1);
        @(negedge clk_s);
        check("rr_grant2", 32'(bus_if.grant), 32'(4'b0100));
        burst(4'b0100, -1);
        @(negedge clk_s);
        check("rr_grant3", 32'(bus_if.grant), 32'(4'b1000));
        burst(4'b1000, -1);
        @(negedge clk_s);
        check("rr_wrap", 32'(bus_if.grant), 32'(4'b0001));
        burst(4'b0001, -1);
        @(negedge clk_s);
        check("rr_grant1b", 32'(bus_if.grant), 32'(4'b0010));
        burst(4'b0010, -1);

        // Priority rotation: ptr is now 2, so 0100 wins over 0001.
        bus_if.req = 4'b0101;
        @(negedge clk_s);
        check("rot_first", 32'(bus_if.grant), 32'(4'b0100));
        burst(4'b0100, -1);
        @(negedge clk_s);
        check("rot_second", 32'(bus_if.grant), 32'(4'b0001));
        burst(4'b0001, -1);

        // Single request held: same requester again SPAN cycles later.
        bus_if.req = 4'b0001;
        @(negedge clk_s);
        check("single_grant", 32'(bus_if.grant), 32'(4'b0001));
        burst(4'b0001, -1);
        @(negedge clk_s);
        check("single_regrant", 32'(bus_if.grant), 32'(4'b0001));

        // Request dropped mid-burst: burst completes, no further grant.
        burst(4'b0001, 5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_s);
            check("drop_no_grant", 32'(bus_if.grant), 32'd0);
            check("drop_led",      32'(bus_if.LED),   32'(2'b10));
        end

        // Reset mid-burst. ptr is 1, so the next grant is 0010.
        bus_if.req = 4'b1111;
        @(negedge clk_s);
        check("mid_grant", 32'(bus_if.grant), 32'(4'b0010));
        for (int i = 0; i < 5; i++) @(negedge clk_s);
        check("mid_led_pre", 32'(bus_if.LED), 32'(2'b10));
        reset_s = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_s);
            check("mid_rst_grant", 32'(bus_if.grant), 32'd0);
            check("mid_rst_done",  32'(bus_if.done),  32'd0);
            check("mid_rst_busy",  32'(bus_if.busy),  32'd0);
            check("mid_rst_led",   32'(bus_if.LED),   32'(2'b10));
        end
        reset_s = 1'b1;
        @(negedge clk_s);
        check("post_rst_grant", 32'(bus_if.grant), 32'(4'b0001));
        check("post_rst_busy",  32'(bus_if.busy),  32'd1);
        check("post_rst_led",   32'(bus_if.LED),   32'(2'b01));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/led_blink_scheduler.md
Name: led_blink_scheduler

Overview:
Shares the board's complementary LED pair between N_REQ requesters using round-robin arbitration.
- A granted requester receives a burst of BLINKS on/off blinks, each phase HALF_PERIOD CLOCK_50 cycles long.
- A GAP-cycle quiet interval follows each burst, then the block re-arbitrates.
- Sits between status sources (error, heartbeat, activity flags) and the LED[1:0] pins; owns the prescaler counter that the blinker used to run on its own.

Parameters:
N_REQ, 4, number of requesters (2..8)
HALF_PERIOD, 5000, cycles per LED phase (ON or OFF), >=2
BLINKS, 3, ON+OFF pairs per grant, 1..255
GAP, 5000, quiet cycles after each burst, >=1
CNT_W, 33, width of the shared phase/gap counter; must hold max(HALF_PERIOD, GAP)

Ports:
CLOCK_50  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-low; sampled on CLOCK_50 posedge
req  input  N_REQ  level request per requester; sampled only in IDLE
grant  output  N_REQ  one-hot owner of the LEDs, 0 when none
done  output  N_REQ  one-cycle pulse on the owner's bit when its burst completes
busy  output  1  high in ON/OFF states
LED  output  2  LED[0]=active indicator, LED[1]=~LED[0] always

Behaviour:
- Reset (reset==0 at posedge): state=IDLE, cnt=0, blinks_left=0, ptr=0, grant=0, done=0, busy=0, LED=2'b10. Reset overrides all other events.
- All outputs are registered; LED[1] is always the complement of LED[0].
- IDLE: LED=10, busy=0.
  - If req!=0, select the first set bit searching ptr, ptr+1, ... mod N_REQ.
  - At that edge: grant=onehot(sel), busy=1, LED=01, cnt=0, blinks_left=BLINKS, go to ON.
  - If req==0, stay in IDLE.
- ON: LED=01; cnt+1 each cycle. When cnt==HALF_PERIOD-1: cnt=0, LED=10, go to OFF.
- OFF: LED=10; cnt+1 each cycle. When cnt==HALF_PERIOD-1: cnt=0.
  - If blinks_left>1: blinks_left-1, LED=01, go to ON.
  - Else: done=grant for one cycle, grant=0, busy=0, ptr=(sel+1) mod N_REQ, go to GAP.
- GAP: LED=10, grant=0. When cnt==GAP-1: cnt=0, go to IDLE.
- Grant-to-grant spacing under continuous request: 2*HALF_PERIOD*BLINKS + GAP + 1 cycles.
- Boundary and simultaneous events:
  - req changes outside IDLE are ignored. Deasserting req mid-burst does not abort; the burst completes and done still pulses.
  - A new req arriving during GAP waits for IDLE.
  - Reset mid-burst aborts immediately: no done pulse, ptr returns to 0.
  - Wrap-around: ptr after requester N_REQ-1 is 0.
  - Only one grant bit is ever set. done is never set on a bit whose grant is 0 in the preceding cycle.
- Counter compares are exact equality on CNT_W bits; cnt never exceeds max(HALF_PERIOD, GAP)-1.

Test Plan:
Common setup: HALF_PERIOD=4, BLINKS=2, GAP=3, N_REQ=4. Edge t is the grant edge.
1. Reset: reset=0 for 2 cycles with req=4'b1111 -> grant=0, done=0, busy=0, LED=2'b10 throughout; first grant=0001 at the first edge with reset=1.
2. Single request: req=0001 sampled at edge t ->
   - grant=0001, busy=1 from t.
   - LED=01 during [t,t+4), 10 during [t+4,t+8), 01 during [t+8,t+12), 10 during [t+12,t+16).
   - At t+16: done=0001 for exactly 1 cycle, grant=0, busy=0.
   - With req held, next grant=0001 at t+20.
3. Round-robin: req=1111 held -> grants 0001, 0010, 0100, 1000, 0001 at t, t+20, t+40, t+60, t+80; a done pulse matches each grant.
4. Priority rotation: after the burst for 0010 completes, req=0101 -> next grant 0100, then 0001 (not 0001 first).
5. Request drop: req[0] falls at t+5 during the 0001 burst -> LED sequence unchanged, done[0] at t+16, no grant to 0001 at t+20.
6. Reset mid-burst: reset=0 at t+6 -> next edge grant=0, LED=10, busy=0, no done pulse; after release with req=1111, grant=0001 (ptr cleared).
